// File: rtl/fc_pkg.sv
// -----------------------------------------------------------------------------
// fc_pkg
// Shared definitions for the fully-connected layer engines.
//   - fc_state_e    : sequencer states of one layer pass
//   - fc_acc_width  : accumulator width that cannot overflow for a layer
//   - fc_convert    : accumulator -> output word (shift, saturate, ReLU)
// fc_convert works on a wide fixed container so every layer can share it,
// whatever its own word and accumulator widths are. Callers sign-extend into
// CONV_ACC_W bits and truncate the CONV_OUT_W result to their word size.
// -----------------------------------------------------------------------------
package fc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } fc_state_e;

    localparam int CONV_ACC_W = 64;
    localparam int CONV_OUT_W = 32;

    // IN_SZ full-width products plus the shifted bias, all summed.
    function automatic int fc_acc_width(input int size, input int in_sz);
        return 2 * size + $clog2(in_sz + 1);
    endfunction

    // Arithmetic shift right by frac (floor toward -inf), saturate to a signed
    // size-bit range, then optionally clamp negatives to zero.
    function automatic logic signed [CONV_OUT_W-1:0] fc_convert(
        input logic signed [CONV_ACC_W-1:0] acc,
        input int                           frac,
        input int                           size,
        input logic                         relu
    );
        logic signed [CONV_ACC_W-1:0] shifted;
        logic signed [CONV_ACC_W-1:0] max_v;
        logic signed [CONV_ACC_W-1:0] min_v;
        shifted = acc >>> frac;
        max_v   = (CONV_ACC_W'(1) <<< (size - 1)) - CONV_ACC_W'(1);
        min_v   = ~max_v;  // -2^(size-1)
        if (shifted > max_v) begin
            shifted = max_v;
        end else if (shifted < min_v) begin
            shifted = min_v;
        end
        if (relu && shifted[CONV_ACC_W-1]) begin
            shifted = '0;
        end
        return shifted[CONV_OUT_W-1:0];
    endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// -----------------------------------------------------------------------------
// fc_mac_unit
// Signed multiply-accumulate datapath for one output neuron at a time.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (acc cleared)
//   clr            clear the accumulator on this edge
//   acc_en         add this cycle's addend on this edge
//   is_bias        addend is w_data << FRAC instead of w_data * x_val
//   relu           clamp negative converted results to zero
//   w_data, x_val  weight/bias word and the matching input neuron value
//   result_d       converted value of the accumulator as it will be after
//                  this edge; the sequencer registers it on the bias cycle
// -----------------------------------------------------------------------------
module fc_mac_unit
    import fc_pkg::*;
#(
    parameter int SIZE  = 16,
    parameter int FRAC  = 8,
    parameter int IN_SZ = 16,
    parameter int ACC_W = fc_acc_width(SIZE, IN_SZ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            acc_en,
    input  logic            is_bias,
    input  logic            relu,
    input  logic [SIZE-1:0] w_data,
    input  logic [SIZE-1:0] x_val,
    output logic [SIZE-1:0] result_d
);

    logic signed [ACC_W-1:0]      acc_q;
    logic signed [ACC_W-1:0]      acc_d;
    logic signed [2*SIZE-1:0]     product;
    logic signed [ACC_W-1:0]      addend;
    logic signed [CONV_ACC_W-1:0] acc_wide;

    always_comb begin
        product = $signed(w_data) * $signed(x_val);
        if (is_bias) begin
            // Bias is aligned to the product's 2*FRAC fractional bits.
            addend = {{(ACC_W-SIZE){w_data[SIZE-1]}}, w_data} << FRAC;
        end else begin
            addend = {{(ACC_W-2*SIZE){product[2*SIZE-1]}}, product};
        end

        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q + addend;
        end

        // ACC_W must stay below CONV_ACC_W for this extension to be legal.
        acc_wide = {{(CONV_ACC_W-ACC_W){acc_d[ACC_W-1]}}, acc_d};
        result_d = SIZE'(fc_convert(acc_wide, FRAC, SIZE, relu));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/fc_layer_engine.sv
// -----------------------------------------------------------------------------
// fc_layer_engine
// Sequential fully-connected layer: for each output neuron j it streams the
// IN_SZ weights and the bias of row j from a synchronous weight memory,
// accumulates w*x + (bias << FRAC), converts, and writes the result into the
// next layer.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          begin a pass (only honoured in IDLE)
//   relu_en        ReLU select, captured together with start
//   in_values      input neuron vector, captured together with start
//   w_addr, w_rd   weight memory read request
//   w_data         weight memory read data
//   load_en        one-cycle write strobe into the next layer
//   load_value     converted output neuron value (registered)
//   load_address   output neuron index (registered)
//   busy           pass in progress
//   done           one-cycle pulse after the last write
//
// Weight memory protocol: there is no ready/stall. A word requested with
// w_rd=1 and w_addr in cycle c is presented on w_data throughout cycle c+1,
// and the engine consumes it in exactly that cycle. Row j occupies addresses
// j*(IN_SZ+1) .. j*(IN_SZ+1)+IN_SZ (weights, then bias), so the read address
// simply counts up across the whole pass.
// -----------------------------------------------------------------------------
module fc_layer_engine
    import fc_pkg::*;
#(
    parameter int SIZE    = 16,
    parameter int FRAC    = 8,
    parameter int IN_SZ   = 16,
    parameter int OUT_SZ  = 10,
    parameter int WADDR_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       relu_en,
    input  logic [0:IN_SZ-1][SIZE-1:0] in_values,
    output logic [WADDR_W-1:0]         w_addr,
    output logic                       w_rd,
    input  logic [SIZE-1:0]            w_data,
    output logic                       load_en,
    output logic [SIZE-1:0]            load_value,
    output logic [SIZE-1:0]            load_address,
    output logic                       busy,
    output logic                       done
);

    // k runs 0..IN_SZ (IN_SZ = bias fetch) and is incremented once more on
    // the bias fetch, hence IN_SZ+2 distinct values.
    localparam int K_W = $clog2(IN_SZ + 2);
    localparam int J_W = (OUT_SZ > 1) ? $clog2(OUT_SZ) : 1;

    fc_state_e                  state_q, state_d;
    logic [K_W-1:0]             k_q, k_d;
    logic [J_W-1:0]             j_q, j_d;
    logic [WADDR_W-1:0]         addr_q, addr_d;
    logic [0:IN_SZ-1][SIZE-1:0] snap_q, snap_d;
    logic                       relu_q, relu_d;
    logic                       load_en_q, load_en_d;
    logic [SIZE-1:0]            load_value_q, load_value_d;
    logic [SIZE-1:0]            load_address_q, load_address_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic                       mac_clr;
    logic                       mac_acc_en;
    logic                       mac_is_bias;
    logic [SIZE-1:0]            mac_result;
    logic [SIZE-1:0]            x_sel;

    // The word on w_data during a FETCH cycle with k_q=m belongs to input m-1.
    always_comb begin
        x_sel = '0;
        for (int i = 0; i < IN_SZ; i++) begin
            if (k_q == K_W'(i + 1)) begin
                x_sel = snap_q[i];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        j_d            = j_q;
        addr_d         = addr_q;
        snap_d         = snap_q;
        relu_d         = relu_q;
        load_en_d      = 1'b0;
        load_value_d   = load_value_q;
        load_address_d = load_address_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        mac_clr        = 1'b0;
        mac_acc_en     = 1'b0;
        mac_is_bias    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    k_d     = '0;
                    j_d     = '0;
                    addr_d  = '0;
                    snap_d  = in_values;
                    relu_d  = relu_en;
                    busy_d  = 1'b1;
                    mac_clr = 1'b1;
                end
            end
            ST_FETCH: begin
                // k_q=0 has no returned word of this row yet.
                mac_acc_en = (k_q != '0);
                addr_d     = addr_q + WADDR_W'(1);
                k_d        = k_q + K_W'(1);
                if (k_q == K_W'(IN_SZ)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Bias arrives now; register the final converted value so it
                // is stable for the whole WRITE cycle.
                mac_acc_en     = 1'b1;
                mac_is_bias    = 1'b1;
                load_en_d      = 1'b1;
                load_value_d   = mac_result;
                load_address_d = SIZE'(j_q);
                state_d        = ST_WRITE;
            end
            ST_WRITE: begin
                if (j_q == J_W'(OUT_SZ - 1)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_FETCH;
                    j_d     = j_q + J_W'(1);
                    k_d     = '0;
                    mac_clr = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            k_q            <= '0;
            j_q            <= '0;
            addr_q         <= '0;
            snap_q         <= '0;
            relu_q         <= 1'b0;
            load_en_q      <= 1'b0;
            load_value_q   <= '0;
            load_address_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            j_q            <= j_d;
            addr_q         <= addr_d;
            snap_q         <= snap_d;
            relu_q         <= relu_d;
            load_en_q      <= load_en_d;
            load_value_q   <= load_value_d;
            load_address_q <= load_address_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    fc_mac_unit #(
        .SIZE  (SIZE),
        .FRAC  (FRAC),
        .IN_SZ (IN_SZ)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (mac_clr),
        .acc_en   (mac_acc_en),
        .is_bias  (mac_is_bias),
        .relu     (relu_q),
        .w_data   (w_data),
        .x_val    (x_sel),
        .result_d (mac_result)
    );

    assign w_rd         = (state_q == ST_FETCH);
    assign w_addr       = addr_q;
    assign load_en      = load_en_q;
    assign load_value   = load_value_q;
    assign load_address = load_address_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
